// File: rtl/shift_add_mult.sv
// Sequential shift-and-add unsigned multiplier: one partial-product step per clock,
// WIDTH steps per operation, abortable, with a one-cycle done pulse and a held product.
module shift_add_mult #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [1:0]         dbg_state_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]     acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     step_hi;
  logic [WIDTH-1:0]     step_lo;

  // Partial sum keeps its carry; the carry becomes the new MSB of acc_hi after the shift.
  always_comb begin
    sum     = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    step_hi = sum[WIDTH:1];
    step_lo = {sum[0], acc_lo_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d   = state_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    mcand_d   = mcand_q;
    count_d   = count_q;
    product_d = product_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_lo_d = multiplier;
          acc_hi_d = '0;
          mcand_d  = multiplicand;
          count_d  = '0;
          state_d  = ST_CALC;
        end
      end
      ST_CALC: begin
        // Abort wins even on the final step, so the product is never updated.
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          acc_hi_d = step_hi;
          acc_lo_d = step_lo;
          count_d  = count_q + 1'b1;
          if (count_q == LAST_STEP) begin
            product_d = {step_hi, step_lo};
            state_d   = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      mcand_q   <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      mcand_q   <= mcand_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign busy        = (state_q == ST_CALC);
  assign done        = (state_q == ST_DONE);
  assign product     = product_q;
  assign dbg_state_o = state_q;

endmodule
